scan_frame_rx: RTL and testbench

Receive end of the multiplexed digit-scan link. Accepts the time-multiplexed 4-bit character codes that the display word driver emits one digit position at a time and rebuilds the full 8-digit, 32-bit display word. Publishes a word only after it has been seen identically on consecutive scans, which suppresses tearing while the driver scrolls. Used as the display loopback/monitor point and as the input stage of the set-time echo path.

---
 rtl/scan_frame_rx.sv | 122 ++++++++++++
 tb/tb_scan_frame_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/scan_frame_rx.sv
// Rebuilds the DIGITS-wide display word from the time-multiplexed digit-scan link.
// A word is published only after STABLE consecutive identical complete frames.
module scan_frame_rx #(
    parameter int DIGITS = 8,
    parameter int CODE_W = 4,
    parameter int STABLE = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CODE_W-1:0]        sc_in,
    input  logic                     sc_valid,
    input  logic                     sc_first,
    output logic [DIGITS*CODE_W-1:0] frame_out,
    output logic                     frame_strobe,
    output logic                     frame_changed,
    output logic                     sync_err,
    output logic                     locked
);
    // state   | meaning
    // HUNT    | waiting for a digit qualified by sc_first
    // COLLECT | aligned; filling slots idx..DIGITS-1
    localparam logic [0:0] S_HUNT    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;

    localparam int          IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          WORD_W   = DIGITS * CODE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [2:0]  STABLE_C = 3'(STABLE);

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [2:0]        r_match_cnt;
    logic [WORD_W-1:0] r_asm;
    logic [WORD_W-1:0] r_prev;
    logic [WORD_W-1:0] r_frame_out;
    logic              r_strobe;
    logic              r_changed;
    logic              r_sync_err;
    logic              r_locked;

    logic [WORD_W-1:0] w_word;
    logic              w_match;
    logic [2:0]        w_cnt_next;

    // The completed word includes the digit being sampled on this edge.
    always_comb begin
        w_word = r_asm;
        w_word[(DIGITS-1)*CODE_W +: CODE_W] = sc_in;
        w_match = (w_word == r_prev);
        w_cnt_next = 3'd1;
        if (w_match) begin
            w_cnt_next = (r_match_cnt >= STABLE_C) ? STABLE_C : r_match_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_HUNT;
            r_idx       <= '0;
            r_match_cnt <= '0;
            r_asm       <= '0;
            r_prev      <= '0;
            r_frame_out <= '0;
            r_strobe    <= 1'b0;
            r_changed   <= 1'b0;
            r_sync_err  <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_strobe   <= 1'b0;
            r_changed  <= 1'b0;
            r_sync_err <= 1'b0;
            if (sc_valid) begin
                case (r_state)
                    S_HUNT: begin
                        if (sc_first) begin
                            r_asm[0 +: CODE_W] <= sc_in;
                            r_idx   <= ONE_IDX;
                            r_state <= S_COLLECT;
                        end
                    end
                    default: begin
                        if (sc_first) begin
                            // A first digit mid-frame re-aligns immediately instead of hunting.
                            if (r_idx != '0) begin
                                r_sync_err  <= 1'b1;
                                r_locked    <= 1'b0;
                                r_match_cnt <= '0;
                            end
                            r_asm[0 +: CODE_W] <= sc_in;
                            r_idx <= ONE_IDX;
                        end else if (r_idx == '0) begin
                            r_sync_err  <= 1'b1;
                            r_locked    <= 1'b0;
                            r_match_cnt <= '0;
                            r_state     <= S_HUNT;
                        end else if (r_idx == LAST_IDX) begin
                            r_idx       <= '0;
                            r_prev      <= w_word;
                            r_match_cnt <= w_cnt_next;
                            r_locked    <= 1'b1;
                            if (w_cnt_next >= STABLE_C) begin
                                r_frame_out <= w_word;
                                r_strobe    <= 1'b1;
                                r_changed   <= (w_word != r_frame_out);
                            end
                        end else begin
                            r_asm[r_idx*CODE_W +: CODE_W] <= sc_in;
                            r_idx <= r_idx + ONE_IDX;
                        end
                    end
                endcase
            end
        end
    end

    assign frame_out     = r_frame_out;
    assign frame_strobe  = r_strobe;
    assign frame_changed = r_changed;
    assign sync_err      = r_sync_err;
    assign locked        = r_locked;
endmodule

// File: tb/tb_scan_frame_rx.sv
// Bench for scan_frame_rx: random words and gaps checked against a run-length model
// of identical consecutive frames.
module tb_scan_frame_rx;
    localparam int DIGITS = 8;
    localparam int CODE_W = 4;
    localparam int STABLE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  sc_in = '0;
    logic        sc_valid = 1'b0;
    logic        sc_first = 1'b0;
    logic [31:0] frame_out;
    logic        frame_strobe, frame_changed, sync_err, locked;

    int checks = 0;
    int failures = 0;

    // Model: length of the current run of identical complete frames, and the published word.
    logic [31:0] m_out = '0;
    logic [31:0] m_last = '0;
    int          m_run = 0;

    scan_frame_rx #(.DIGITS(DIGITS), .CODE_W(CODE_W), .STABLE(STABLE)) dut (
        .clk(clk), .reset(reset), .sc_in(sc_in), .sc_valid(sc_valid), .sc_first(sc_first),
        .frame_out(frame_out), .frame_strobe(frame_strobe), .frame_changed(frame_changed),
        .sync_err(sync_err), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] code, input logic v, input logic f);
        @(negedge clk);
        sc_in = code; sc_valid = v; sc_first = f;
        @(posedge clk);
        #1;
    endtask

    task automatic model_frame(input logic [31:0] w, output logic e_strobe, output logic e_changed);
        m_run = (m_run > 0 && w == m_last) ? m_run + 1 : 1;
        m_last = w;
        e_strobe = (m_run >= STABLE);
        e_changed = e_strobe && (w != m_out);
        if (e_strobe) m_out = w;
    endtask

    task automatic send_frame(input logic [31:0] w, input int start, input int gap_max, input string name);
        logic es, ec;
        int spurious;
        int g;
        spurious = 0;
        for (int i = start; i < DIGITS; i++) begin
            drive(w[4*i +: 4], 1'b1, i == 0);
            if (i < DIGITS - 1) begin
                if (frame_strobe || sync_err) spurious++;
                g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
                for (int k = 0; k < g; k++) begin
                    drive($urandom_range(15, 0), 1'b0, $urandom_range(1, 0));
                    if (frame_strobe || sync_err) spurious++;
                end
            end
        end
        model_frame(w, es, ec);
        checks += 6;
        if (frame_strobe !== es) begin failures++; $display("FAIL %s strobe: got %b want %b", name, frame_strobe, es); end
        if (frame_changed !== ec) begin failures++; $display("FAIL %s changed: got %b want %b", name, frame_changed, ec); end
        if (frame_out !== m_out) begin failures++; $display("FAIL %s frame_out: got %h want %h", name, frame_out, m_out); end
        if (locked !== 1'b1) begin failures++; $display("FAIL %s locked: got %b want 1", name, locked); end
        if (sync_err !== 1'b0) begin failures++; $display("FAIL %s sync_err: got %b want 0", name, sync_err); end
        if (spurious != 0) begin failures++; $display("FAIL %s mid-frame pulses: got %0d want 0", name, spurious); end
    endtask

    task automatic check_all_zero(input string name);
        checks += 5;
        if (frame_out !== 32'h0) begin failures++; $display("FAIL %s frame_out: got %h want 0", name, frame_out); end
        if (frame_strobe !== 1'b0) begin failures++; $display("FAIL %s strobe: got %b want 0", name, frame_strobe); end
        if (frame_changed !== 1'b0) begin failures++; $display("FAIL %s changed: got %b want 0", name, frame_changed); end
        if (sync_err !== 1'b0) begin failures++; $display("FAIL %s sync_err: got %b want 0", name, sync_err); end
        if (locked !== 1'b0) begin failures++; $display("FAIL %s locked: got %b want 0", name, locked); end
    endtask

    task automatic check_sync_err(input string name);
        checks += 2;
        if (sync_err !== 1'b1) begin failures++; $display("FAIL %s sync_err: got %b want 1", name, sync_err); end
        if (locked !== 1'b0) begin failures++; $display("FAIL %s locked: got %b want 0", name, locked); end
        m_run = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        m_out = '0; m_last = '0; m_run = 0;
    endtask

    task automatic test_basic();
        send_frame(32'h12345678, 0, 0, "basic_f1");
        send_frame(32'h12345678, 0, 0, "basic_f2");
        send_frame(32'h12345678, 0, 0, "basic_f3");
    endtask

    task automatic test_abb();
        send_frame(32'h11111111, 0, 0, "abb_a");
        send_frame(32'h22222222, 0, 0, "abb_b1");
        send_frame(32'h22222222, 0, 0, "abb_b2");
    endtask

    task automatic test_first_mid();
        logic [31:0] x, w;
        x = $urandom; w = $urandom;
        for (int i = 0; i < 5; i++) drive(x[4*i +: 4], 1'b1, i == 0);
        drive(w[3:0], 1'b1, 1'b1);
        check_sync_err("first_mid");
        send_frame(w, 1, 0, "first_mid_f1");
        send_frame(w, 0, 0, "first_mid_f2");
    endtask

    task automatic test_no_first();
        logic [31:0] w;
        int bad;
        w = $urandom;
        send_frame(32'hA5A5A5A5, 0, 0, "nofirst_pre");
        drive(4'h5, 1'b1, 1'b0);
        check_sync_err("nofirst");
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            drive($urandom_range(15, 0), $urandom_range(1, 0), 1'b0);
            if (sync_err || frame_strobe || locked) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL hunt_ignore: got %0d pulses want 0", bad); end
        send_frame(w, 0, 5, "nofirst_f1");
        send_frame(w, 0, 5, "nofirst_f2");
    endtask

    task automatic test_random();
        logic [31:0] pool [3];
        for (int i = 0; i < 3; i++) pool[i] = $urandom;
        for (int n = 0; n < 10; n++) begin
            logic [31:0] w;
            w = pool[$urandom_range(2, 0)];
            send_frame(w, 0, 5, "random");
            if ($urandom_range(1, 0) == 1) send_frame(w, 0, 5, "random_rep");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        w = $urandom;
        for (int n = 0; n < 3; n++) send_frame(w, 0, 0, "b2b");
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        w = $urandom | 32'h1;
        for (int i = 0; i < 4; i++) drive(w[4*i +: 4], 1'b1, i == 0);
        @(negedge clk);
        sc_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_all_zero("reset_mid");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_out = '0; m_last = '0; m_run = 0;
        drive(4'h3, 1'b1, 1'b0);
        checks++;
        if (sync_err !== 1'b0 || locked !== 1'b0) begin
            failures++; $display("FAIL post_reset_hunt: got sync_err=%b locked=%b want 0 0", sync_err, locked);
        end
        send_frame(w, 0, 0, "reset_mid_f1");
        send_frame(w, 0, 0, "reset_mid_f2");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abb();
        test_first_mid();
        test_no_first();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
